op_mailbox_host: RTL and testbench

- Host-side initiator for the op-mailbox protocol that the compute sequencer serves.
- Accepts one command from upstream (valid/ready), writes the scalar word (scalar ops only) and then the packed op descriptor into op memory.
- Polls the op word until the sequencer clears it to 0, signalling completion.
- Streams the result region out on a valid/ready/last interface; owns the op-memory write side and the result-memory read side.

---
 rtl/op_mailbox_host.sv | 197 +++++++++++++++++++
 tb/tb_op_mailbox_host.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_mailbox_host.sv
// Host-side initiator for the op-mailbox protocol: writes a command into op
// memory, polls the op word until cleared, then streams the result region.
module op_mailbox_host #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int OP_WIDTH    = 4,
    parameter int DIM_WIDTH   = 7,
    parameter int OP_ADDR     = 0,
    parameter int SCALAR_ADDR = 1,
    parameter int RES_ADDR    = 0,
    parameter int POLL_GAP    = 4,
    parameter int MAX_POLLS   = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [DIM_WIDTH-1:0]  cmd_dimA1,
    input  logic [DIM_WIDTH-1:0]  cmd_dimA2,
    input  logic [DIM_WIDTH-1:0]  cmd_dimB1,
    input  logic [DIM_WIDTH-1:0]  cmd_dimB2,
    input  logic [DATA_WIDTH-1:0] cmd_scalar,
    output logic [ADDR_WIDTH-1:0] op_addr,
    output logic                  op_read,
    output logic                  op_write,
    output logic [DATA_WIDTH-1:0] op_writedata,
    input  logic [DATA_WIDTH-1:0] op_readdata,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic                  res_read,
    input  logic [DATA_WIDTH-1:0] res_readdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  error
);

    localparam int NW     = 2 * (DIM_WIDTH - 2);
    localparam int PW     = $clog2(MAX_POLLS + 1);
    localparam int DESC_W = OP_WIDTH + 4 * DIM_WIDTH;

    typedef enum logic [3:0] {
        IDLE, WR_SCALAR, WR_OP, GAP, POLL_RD,
        POLL_CHK, RES_RD, RES_CAP, RES_OUT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] desc_q;
    logic [NW-1:0]         n_words;
    logic [NW-1:0]         idx;
    logic [PW-1:0]         poll_cnt;
    logic [7:0]            gap_cnt;

    logic [DESC_W-1:0]     cmd_desc;
    logic [NW-1:0]         cmd_n;
    logic                  op_bad;
    logic                  op_scalar;

    assign cmd_desc  = {cmd_op, cmd_dimA1, cmd_dimA2, cmd_dimB1, cmd_dimB2};
    assign cmd_n     = NW'(cmd_dimA1[DIM_WIDTH-1:2])
                     * NW'(cmd_dimA2[DIM_WIDTH-1:2]);
    assign op_bad    = (cmd_op == '0) || (cmd_op > OP_WIDTH'(8));
    assign op_scalar = (cmd_op >= OP_WIDTH'(2)) && (cmd_op <= OP_WIDTH'(5));

    // Outputs are registered: each branch sets what the next state drives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            desc_q       <= '0;
            n_words      <= '0;
            idx          <= '0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
            cmd_ready    <= 1'b1;
            op_addr      <= '0;
            op_read      <= 1'b0;
            op_write     <= 1'b0;
            op_writedata <= '0;
            res_addr     <= '0;
            res_read     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            op_read  <= 1'b0;
            op_write <= 1'b0;
            res_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        desc_q  <= DATA_WIDTH'(cmd_desc);
                        n_words <= cmd_n;
                        error   <= 1'b0;
                        if (op_bad) begin
                            error <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            op_write  <= 1'b1;
                            if (op_scalar) begin
                                state        <= WR_SCALAR;
                                op_addr      <= ADDR_WIDTH'(SCALAR_ADDR);
                                op_writedata <= cmd_scalar;
                            end else begin
                                state        <= WR_OP;
                                op_addr      <= ADDR_WIDTH'(OP_ADDR);
                                op_writedata <= DATA_WIDTH'(cmd_desc);
                            end
                        end
                    end
                end
                WR_SCALAR: begin
                    state        <= WR_OP;
                    op_write     <= 1'b1;
                    op_addr      <= ADDR_WIDTH'(OP_ADDR);
                    op_writedata <= desc_q;
                end
                WR_OP: begin
                    state    <= GAP;
                    poll_cnt <= '0;
                    gap_cnt  <= '0;
                end
                GAP: begin
                    if (gap_cnt == 8'(POLL_GAP - 1)) begin
                        state   <= POLL_RD;
                        op_read <= 1'b1;
                        op_addr <= ADDR_WIDTH'(OP_ADDR);
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                POLL_RD: begin
                    state    <= POLL_CHK;
                    poll_cnt <= poll_cnt + PW'(1);
                end
                POLL_CHK: begin
                    if (op_readdata == '0) begin
                        if (n_words == '0) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state    <= RES_RD;
                            idx      <= '0;
                            res_read <= 1'b1;
                            res_addr <= ADDR_WIDTH'(RES_ADDR);
                        end
                    end else if (poll_cnt == PW'(MAX_POLLS)) begin
                        state     <= IDLE;
                        error     <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                RES_RD: begin
                    state <= RES_CAP;
                end
                RES_CAP: begin
                    state     <= RES_OUT;
                    out_data  <= res_readdata;
                    out_valid <= 1'b1;
                    out_last  <= (idx == n_words - NW'(1));
                end
                RES_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state    <= RES_RD;
                            idx      <= idx + NW'(1);
                            res_read <= 1'b1;
                            res_addr <= ADDR_WIDTH'(RES_ADDR)
                                      + ADDR_WIDTH'(idx + NW'(1));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_mailbox_host.sv
// Randomized bench for op_mailbox_host with a memory stub and a
// transaction-level reference model.
module tb_op_mailbox_host;

    localparam int MAXP = 8;
    localparam int GAPC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [6:0]  cmd_dimA1 = '0, cmd_dimA2 = '0;
    logic [6:0]  cmd_dimB1 = '0, cmd_dimB2 = '0;
    logic [31:0] cmd_scalar = '0;
    logic [15:0] op_addr;
    logic        op_read, op_write;
    logic [31:0] op_writedata;
    logic [31:0] op_readdata = '0;
    logic [15:0] res_addr;
    logic        res_read;
    logic [31:0] res_readdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy, error;

    op_mailbox_host #(.POLL_GAP(GAPC), .MAX_POLLS(MAXP)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_dimA1(cmd_dimA1), .cmd_dimA2(cmd_dimA2),
        .cmd_dimB1(cmd_dimB1), .cmd_dimB2(cmd_dimB2),
        .cmd_scalar(cmd_scalar),
        .op_addr(op_addr), .op_read(op_read), .op_write(op_write),
        .op_writedata(op_writedata), .op_readdata(op_readdata),
        .res_addr(res_addr), .res_read(res_read),
        .res_readdata(res_readdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory stub: op word cleared on the clear_at-th poll after a write.
    logic [31:0] res_mem [0:1023];
    logic [31:0] op_word = '0;
    int          stub_polls = 0;
    int          clear_at = 1;

    always @(posedge clock) begin
        if (op_write && op_addr == 16'd0) begin
            op_word    <= op_writedata;
            stub_polls <= 0;
        end
        if (op_read) begin
            stub_polls  <= stub_polls + 1;
            op_readdata <= (stub_polls + 1 >= clear_at) ? 32'd0 : op_word;
        end
        if (res_read)
            res_readdata <= res_mem[res_addr[9:0]];
    end

    logic hold_rdy = 1'b1;
    always @(posedge clock) begin
        #1;
        out_ready = hold_rdy ? 1'b0 : (($urandom % 3) != 0);
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Observed transaction log
    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rd_cyc_q[$];
    logic [15:0] res_addr_q[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    int          ovl_viol = 0;
    int          stab_viol = 0;
    logic        prev_v = 1'b0, prev_hs = 1'b0;
    logic [31:0] prev_d = '0;

    always @(negedge clock) begin
        if (op_write) begin
            wr_addr_q.push_back(op_addr);
            wr_data_q.push_back(op_writedata);
        end
        if (op_read) begin
            rd_cyc_q.push_back(cyc);
            if (op_addr != 16'd0) ovl_viol++;
        end
        if (op_read && op_write) ovl_viol++;
        if (res_read) res_addr_q.push_back(res_addr);
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (!reset && prev_v && !prev_hs &&
            (!out_valid || out_data !== prev_d))
            stab_viol++;
        prev_v  = out_valid && !reset;
        prev_hs = out_valid && out_ready;
        prev_d  = out_data;
    end

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); rd_cyc_q.delete();
        res_addr_q.delete(); out_q.delete(); last_q.delete();
        ovl_viol = 0; stab_viol = 0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [6:0] a1,
                         input logic [6:0] a2, input logic [6:0] b1,
                         input logic [6:0] b2, input logic [31:0] sc);
        @(posedge clock); #1;
        cmd_op = op; cmd_dimA1 = a1; cmd_dimA2 = a2;
        cmd_dimB1 = b1; cmd_dimB2 = b2; cmd_scalar = sc;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_op = $urandom_range(1, 8);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [6:0] a1,
                           input logic [6:0] a2, input logic [6:0] b1,
                           input logic [6:0] b2, input logic [31:0] sc,
                           input int clr);
        bit   valid, scal, tmo;
        int   n, nout, npoll, gap_bad, w;
        logic [31:0] desc;
        clear_log();
        clear_at = clr;
        offer(op, a1, a2, b1, b2, sc);
        w = 0;
        while (!(cmd_ready && !busy) && w < 4000) begin
            @(negedge clock); w++;
        end
        check("done_in_time", w < 4000, 1);
        repeat (2) @(negedge clock);

        valid = op >= 1 && op <= 8;
        scal  = op >= 2 && op <= 5;
        n     = (int'(a1) / 4) * (int'(a2) / 4);
        npoll = !valid ? 0 : (clr < MAXP ? clr : MAXP);
        tmo   = valid && clr > MAXP;
        nout  = (valid && !tmo) ? n : 0;
        desc  = {op, a1, a2, b1, b2};

        check("n_writes", wr_addr_q.size(), !valid ? 0 : (scal ? 2 : 1));
        if (valid && wr_addr_q.size() == (scal ? 2 : 1)) begin
            if (scal) begin
                check("scalar_addr", wr_addr_q[0], 1);
                check("scalar_data", wr_data_q[0], sc);
            end
            check("desc_addr", wr_addr_q[wr_addr_q.size()-1], 0);
            check("desc_data", wr_data_q[wr_data_q.size()-1], desc);
        end
        check("n_polls", rd_cyc_q.size(), npoll);
        gap_bad = 0;
        for (int i = 1; i < rd_cyc_q.size(); i++)
            if (rd_cyc_q[i] - rd_cyc_q[i-1] != GAPC + 2) gap_bad++;
        check("poll_spacing", gap_bad, 0);
        check("error", error, !valid || tmo);
        check("cmd_ready", cmd_ready, 1);
        check("n_res_reads", res_addr_q.size(), nout);
        check("n_out", out_q.size(), nout);
        for (int i = 0; i < nout && i < out_q.size(); i++) begin
            check("res_addr", res_addr_q[i], i);
            check("out_data", out_q[i], res_mem[i]);
            check("out_last", last_q[i], i == nout - 1);
        end
        check("strobe_excl", ovl_viol, 0);
        check("out_stable", stab_viol, 0);
    endtask

    initial begin
        int w, nstrb;
        logic [31:0] d0;
        for (int i = 0; i < 1024; i++) res_mem[i] = $urandom;

        #12;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_outs", {op_read, op_write, res_read, out_valid,
                           out_last, error}, 0);
        @(negedge clock); reset = 1'b0;

        hold_rdy = 1'b0;
        run_cmd(4'd1, 7'd8, 7'd8, 7'd3, 7'd5, 32'h0, 3);
        run_cmd(4'd2, 7'd4, 7'd4, 7'd0, 7'd0, 32'h4000_0000, 1);
        run_cmd(4'd0, 7'd8, 7'd8, 7'd1, 7'd1, 32'h1, 1);
        run_cmd(4'd9, 7'd8, 7'd8, 7'd1, 7'd1, 32'h1, 1);
        run_cmd(4'd8, 7'd12, 7'd4, 7'd2, 7'd2, 32'h0, 2);
        run_cmd(4'd1, 7'd8, 7'd8, 7'd8, 7'd8, 32'h0, 1000);
        run_cmd(4'd1, 7'd2, 7'd8, 7'd8, 7'd8, 32'h0, 1);
        run_cmd(4'd3, 7'd4, 7'd8, 7'd8, 7'd8, 32'h55, MAXP);

        for (int t = 0; t < 40; t++)
            run_cmd(4'($urandom_range(0, 10)), 7'($urandom_range(0, 40)),
                    7'($urandom_range(0, 40)), 7'($urandom),
                    7'($urandom), $urandom, $urandom_range(1, MAXP + 2));

        // Stall mid-stream, then reset asynchronously
        hold_rdy = 1'b1;
        clear_log();
        clear_at = 1;
        offer(4'd1, 7'd8, 7'd8, 7'd0, 7'd0, 32'h0);
        w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clock); w++;
        end
        check("stall_valid_seen", out_valid, 1);
        d0 = out_data;
        check("stall_first_word", d0, res_mem[0]);
        repeat (10) @(negedge clock);
        check("stall_hold", {out_valid, out_data}, {1'b1, res_mem[0]});
        check("stall_stable", stab_viol, 0);
        #3 reset = 1'b1;
        #1;
        check("arst_outs", {op_read, op_write, res_read, out_valid,
                            out_last, busy, error, out_data,
                            op_writedata, op_addr, res_addr}, 0);
        check("arst_ready", cmd_ready, 1);
        nstrb = wr_addr_q.size() + rd_cyc_q.size() + res_addr_q.size();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("arst_no_access",
              wr_addr_q.size() + rd_cyc_q.size() + res_addr_q.size(),
              nstrb);
        check("arst_idle", {cmd_ready, busy, out_valid}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
